// File: rtl/sdf_bitrev_reorder.sv
// sdf_bitrev_reorder
// Re-orders each N-point frame emitted in bit-reversed order by the SDF FFT
// core into natural bin order. Two N-entry complex banks live in one 2N-entry
// RAM with the bank number as the address MSB. The writer fills one bank while
// the reader drains the other. There is no backpressure in either direction.
module sdf_bitrev_reorder #(
    parameter int N      = 64,
    parameter int LOG2N  = $clog2(N),
    parameter int WIDTH  = 8,
    parameter bit BITREV = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_in,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    enable_out,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Mirror the index bits: bit i of the result is bit LOG2N-1-i of idx.
    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] rev;
        rev = {LOG2N{1'b0}};
        for (int i = 0; i < LOG2N; i++) begin
            rev[i] = idx[LOG2N-1-i];
        end
        return rev;
    endfunction

    // Frame storage. It is deliberately not reset, so it can map onto block RAM.
    logic [2*WIDTH-1:0] mem_r [0:2*N-1];

    // Write side
    logic [LOG2N-1:0]   wcnt_r;
    logic               wbank_r;
    logic               fdone_r;     // one-cycle pulse: a bank has just been filled
    logic               fd_bank_r;   // the bank that fdone_r refers to
    logic [LOG2N-1:0]   wr_addr_s;

    // Read side
    state_t             state_r;
    logic [LOG2N-1:0]   rcnt_r;
    logic               rbank_r;
    logic [2*WIDTH-1:0] rd_word_s;

    // Write address: bit-reversed input index, or identity for a plain frame delay.
    always_comb begin
        wr_addr_s = wcnt_r;
        if (BITREV) begin
            wr_addr_s = bit_reverse(wcnt_r);
        end else begin
            wr_addr_s = wcnt_r;
        end
    end

    // Word addressed by the reader in the current RUN cycle. It is captured by the output registers.
    always_comb begin
        rd_word_s = mem_r[{rbank_r, rcnt_r}];
    end

    // RAM write port: store each valid sample in the bank being filled.
    always_ff @(posedge clk) begin
        if (enable_in) begin
            mem_r[{wbank_r, wr_addr_s}] <= {in_re, in_im};
        end
    end

    // Write counter. Wrapping past N-1 swaps banks and signals frame-done.
    // Gaps in enable_in simply hold the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r    <= {LOG2N{1'b0}};
            wbank_r   <= 1'b0;
            fdone_r   <= 1'b0;
            fd_bank_r <= 1'b0;
        end else begin
            if (enable_in) begin
                if (wcnt_r == LAST_IDX) begin
                    wcnt_r    <= {LOG2N{1'b0}};
                    wbank_r   <= ~wbank_r;
                    fdone_r   <= 1'b1;
                    fd_bank_r <= wbank_r;
                end else begin
                    wcnt_r    <= wcnt_r + LOG2N'(1);
                    fdone_r   <= 1'b0;
                end
            end else begin
                fdone_r <= 1'b0;
            end
        end
    end

    // Read FSM with registered outputs. It drains a filled bank in natural
    // order and chains straight into the next bank when frame-done lands on
    // the final read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rcnt_r     <= {LOG2N{1'b0}};
            rbank_r    <= 1'b0;
            enable_out <= 1'b0;
            out_last   <= 1'b0;
            out_re     <= {WIDTH{1'b0}};
            out_im     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    enable_out <= 1'b0;
                    out_last   <= 1'b0;
                    rcnt_r     <= {LOG2N{1'b0}};
                    if (fdone_r) begin
                        state_r <= ST_RUN;
                        rbank_r <= fd_bank_r;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    enable_out <= 1'b1;
                    out_re     <= rd_word_s[2*WIDTH-1:WIDTH];
                    out_im     <= rd_word_s[WIDTH-1:0];
                    out_last   <= (rcnt_r == LAST_IDX);
                    if (rcnt_r == LAST_IDX) begin
                        rcnt_r <= {LOG2N{1'b0}};
                        if (fdone_r) begin
                            state_r <= ST_RUN;
                            rbank_r <= fd_bank_r;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        rcnt_r  <= rcnt_r + LOG2N'(1);
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rcnt_r     <= {LOG2N{1'b0}};
                    enable_out <= 1'b0;
                    out_last   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Testbench for sdf_bitrev_reorder.
// Instance A: N=64, BITREV=1. Instance B: N=8, BITREV=0, used as a plain frame delay.
module tb_sdf_bitrev_reorder;

    logic clk;
    logic rst_n;

    logic              en_a, eo_a, last_a;
    logic signed [7:0] re_a, im_a, ore_a, oim_a;
    logic              en_b, eo_b, last_b;
    logic signed [7:0] re_b, im_b, ore_b, oim_b;

    sdf_bitrev_reorder #(.N(64), .WIDTH(8), .BITREV(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable_in(en_a), .in_re(re_a), .in_im(im_a),
        .enable_out(eo_a), .out_re(ore_a), .out_im(oim_a), .out_last(last_a)
    );

    sdf_bitrev_reorder #(.N(8), .WIDTH(8), .BITREV(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable_in(en_b), .in_re(re_b), .in_im(im_b),
        .enable_out(eo_b), .out_re(ore_b), .out_im(oim_b), .out_last(last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int re;
        int im;
        int last;
    } obs_t;

    obs_t qa[$];
    obs_t qb[$];

    // Capture valid output beats away from the active edge.
    always @(negedge clk) begin
        if (eo_a) qa.push_back('{cyc, int'(ore_a), int'(oim_a), int'(last_a)});
        if (eo_b) qb.push_back('{cyc, int'(ore_b), int'(oim_b), int'(last_b)});
    end

    typedef struct {
        logic signed [7:0] in_re;
        logic signed [7:0] in_im;
        logic signed [7:0] exp_re;
        logic signed [7:0] exp_im;
        logic              exp_last;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_re [0:127];
    int exp_im [0:127];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int brev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if ((v >> i) & 1) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    task automatic drive_a(input logic en, input int re, input int im);
        @(negedge clk);
        en_a = en;
        re_a = 8'(re);
        im_a = 8'(im);
    endtask

    // Compare captured instance-A beats against exp_re/exp_im, contiguity and out_last.
    task automatic check_a(input string tag, input int n, input int t_first);
        chk({tag, "_count"}, qa.size(), n);
        for (int i = 0; i < n && i < qa.size(); i++) begin
            chk($sformatf("%s_re[%0d]", tag, i), qa[i].re, exp_re[i]);
            chk($sformatf("%s_im[%0d]", tag, i), qa[i].im, exp_im[i]);
            chk($sformatf("%s_last[%0d]", tag, i), qa[i].last, ((i % 64) == 63) ? 1 : 0);
            chk($sformatf("%s_cyc[%0d]", tag, i), qa[i].cyc, t_first + i);
        end
    endtask

    vec_t vb [0:7];
    int   t0;

    initial begin
        // Directed table for the N=8 identity instance.
        vb[0] = '{-8'sd128,  8'sd0,    -8'sd128,  8'sd0,    1'b0};
        vb[1] = '{ 8'sd127, -8'sd128,   8'sd127, -8'sd128,  1'b0};
        vb[2] = '{-8'sd1,    8'sd127,  -8'sd1,    8'sd127,  1'b0};
        vb[3] = '{ 8'sd0,   -8'sd1,     8'sd0,   -8'sd1,    1'b0};
        vb[4] = '{ 8'sd1,    8'sd5,     8'sd1,    8'sd5,    1'b0};
        vb[5] = '{-8'sd2,   -8'sd5,    -8'sd2,   -8'sd5,    1'b0};
        vb[6] = '{ 8'sd64,   8'sd100,   8'sd64,   8'sd100,  1'b0};
        vb[7] = '{-8'sd65,  -8'sd100,  -8'sd65,  -8'sd100,  1'b1};

        rst_n = 1'b0;
        en_a = 1'b0; re_a = 8'sd0; im_a = 8'sd0;
        en_b = 1'b0; re_b = 8'sd0; im_b = 8'sd0;
        repeat (3) @(negedge clk);
        chk("rst_enable_out", int'(eo_a), 0);
        chk("rst_out_last", int'(last_a), 0);
        chk("rst_out_re", int'(ore_a), 0);
        chk("rst_out_im", int'(oim_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: gap-free bit-reversed frame.
        qa.delete();
        for (int k = 0; k < 64; k++) begin
            drive_a(1'b1, brev(k, 6), -brev(k, 6));
            if (k == 0) t0 = cyc;
        end
        drive_a(1'b0, 0, 0);
        repeat (80) @(negedge clk);
        for (int j = 0; j < 64; j++) begin
            exp_re[j] = j;
            exp_im[j] = -j;
        end
        check_a("order", 64, t0 + 66);

        // Test 2: back-to-back frames with no bubble.
        qa.delete();
        for (int k = 0; k < 128; k++) begin
            if (k < 64) drive_a(1'b1, brev(k, 6), -brev(k, 6));
            else        drive_a(1'b1, brev(k - 64, 6), brev(k - 64, 6) - 64);
            if (k == 0) t0 = cyc;
        end
        drive_a(1'b0, 0, 0);
        repeat (80) @(negedge clk);
        for (int j = 0; j < 64; j++) begin
            exp_re[j]      = j;
            exp_im[j]      = -j;
            exp_re[j + 64] = j;
            exp_im[j + 64] = j - 64;
        end
        check_a("b2b", 128, t0 + 66);

        // Test 3: gapped input, alternating valid and idle cycles.
        qa.delete();
        for (int k = 0; k < 64; k++) begin
            drive_a(1'b1, brev(k, 6), -brev(k, 6));
            t0 = cyc;
            drive_a(1'b0, 0, 0);
        end
        repeat (80) @(negedge clk);
        for (int j = 0; j < 64; j++) begin
            exp_re[j] = j;
            exp_im[j] = -j;
        end
        check_a("gap", 64, t0 + 3);

        // Test 4: reset after a 20-sample partial frame, then a full new frame.
        qa.delete();
        for (int k = 0; k < 20; k++) drive_a(1'b1, -50, 50);
        @(negedge clk);
        en_a  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_enable_out", int'(eo_a), 0);
        chk("midrst_out_re", int'(ore_a), 0);
        chk("midrst_out_im", int'(oim_a), 0);
        chk("midrst_out_last", int'(last_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            drive_a(1'b1, brev(k, 6), k);
            if (k == 0) t0 = cyc;
        end
        drive_a(1'b0, 0, 0);
        repeat (80) @(negedge clk);
        for (int j = 0; j < 64; j++) begin
            exp_re[j] = j;
            exp_im[j] = brev(j, 6);
        end
        check_a("rstframe", 64, t0 + 66);

        // Test 5: N=8, BITREV=0, sign extremes pass bit-exact in input order.
        qb.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_b = 1'b1;
            re_b = vb[k].in_re;
            im_b = vb[k].in_im;
            if (k == 0) t0 = cyc;
        end
        @(negedge clk);
        en_b = 1'b0;
        repeat (20) @(negedge clk);
        chk("id_count", qb.size(), 8);
        for (int i = 0; i < 8 && i < qb.size(); i++) begin
            chk($sformatf("id_re[%0d]", i), qb[i].re, int'(vb[i].exp_re));
            chk($sformatf("id_im[%0d]", i), qb[i].im, int'(vb[i].exp_im));
            chk($sformatf("id_last[%0d]", i), qb[i].last, int'(vb[i].exp_last));
            chk($sformatf("id_cyc[%0d]", i), qb[i].cyc, t0 + 10 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
